led_scroll_ctrl: RTL and testbench



---
 rtl/led_scroll_pkg.sv | 44 ++++
 rtl/seg16_font.sv | 45 ++++
 rtl/led_scroll_ctrl.sv | 174 +++++++++++++++++
 tb/tb_led_scroll_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scroll_pkg.sv
// Shared types and constants for the 16-segment scroll sequencer.
// Optional hold feature in led_scroll_ctrl is enabled by LED_SCROLL_HOLD_EN.
package led_scroll_pkg;

    localparam int CHAR_W_DEF   = 6;
    localparam int DRAIN_SHIFTS = 4;
    localparam logic [15:0] BLANK_GLYPH = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Character codes: 0 is blank, 1..26 map to A..Z, everything else is blank.
    localparam logic [CHAR_W_DEF-1:0] CH_BLANK = 6'd0;
    localparam logic [CHAR_W_DEF-1:0] CH_A = 6'd1;
    localparam logic [CHAR_W_DEF-1:0] CH_B = 6'd2;
    localparam logic [CHAR_W_DEF-1:0] CH_C = 6'd3;
    localparam logic [CHAR_W_DEF-1:0] CH_D = 6'd4;
    localparam logic [CHAR_W_DEF-1:0] CH_E = 6'd5;
    localparam logic [CHAR_W_DEF-1:0] CH_F = 6'd6;
    localparam logic [CHAR_W_DEF-1:0] CH_G = 6'd7;
    localparam logic [CHAR_W_DEF-1:0] CH_H = 6'd8;
    localparam logic [CHAR_W_DEF-1:0] CH_I = 6'd9;
    localparam logic [CHAR_W_DEF-1:0] CH_J = 6'd10;
    localparam logic [CHAR_W_DEF-1:0] CH_K = 6'd11;
    localparam logic [CHAR_W_DEF-1:0] CH_L = 6'd12;
    localparam logic [CHAR_W_DEF-1:0] CH_M = 6'd13;
    localparam logic [CHAR_W_DEF-1:0] CH_N = 6'd14;
    localparam logic [CHAR_W_DEF-1:0] CH_O = 6'd15;
    localparam logic [CHAR_W_DEF-1:0] CH_P = 6'd16;
    localparam logic [CHAR_W_DEF-1:0] CH_Q = 6'd17;
    localparam logic [CHAR_W_DEF-1:0] CH_R = 6'd18;
    localparam logic [CHAR_W_DEF-1:0] CH_S = 6'd19;
    localparam logic [CHAR_W_DEF-1:0] CH_T = 6'd20;
    localparam logic [CHAR_W_DEF-1:0] CH_U = 6'd21;
    localparam logic [CHAR_W_DEF-1:0] CH_V = 6'd22;
    localparam logic [CHAR_W_DEF-1:0] CH_W = 6'd23;
    localparam logic [CHAR_W_DEF-1:0] CH_X = 6'd24;
    localparam logic [CHAR_W_DEF-1:0] CH_Y = 6'd25;
    localparam logic [CHAR_W_DEF-1:0] CH_Z = 6'd26;

endpackage

// File: rtl/seg16_font.sv
// Combinational character-code to active-low 16-segment glyph lookup.
// Bit order: a1 a2 b c d2 d1 e f g1 g2 h i j k l m (bit 15 down to bit 0).
module seg16_font
    import led_scroll_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEF
) (
    input  logic [CHAR_W-1:0] code,
    output logic [15:0]       glyph
);

    always_comb begin
        glyph = BLANK_GLYPH;
        case (code)
            CHAR_W'(CH_A): glyph = 16'h0C3F;
            CHAR_W'(CH_B): glyph = 16'h03AD;
            CHAR_W'(CH_C): glyph = 16'h30FF;
            CHAR_W'(CH_D): glyph = 16'h03ED;
            CHAR_W'(CH_E): glyph = 16'h307F;
            CHAR_W'(CH_F): glyph = 16'h3C7F;
            CHAR_W'(CH_G): glyph = 16'h20BF;
            CHAR_W'(CH_H): glyph = 16'hCC3F;
            CHAR_W'(CH_I): glyph = 16'h33ED;
            CHAR_W'(CH_J): glyph = 16'hC1FF;
            CHAR_W'(CH_K): glyph = 16'hFC76;
            CHAR_W'(CH_L): glyph = 16'hF0FF;
            CHAR_W'(CH_M): glyph = 16'hCCD7;
            CHAR_W'(CH_N): glyph = 16'hCCDE;
            CHAR_W'(CH_O): glyph = 16'h00FF;
            CHAR_W'(CH_P): glyph = 16'h1C3F;
            CHAR_W'(CH_Q): glyph = 16'h00FE;
            CHAR_W'(CH_R): glyph = 16'h1C3E;
            CHAR_W'(CH_S): glyph = 16'h223F;
            CHAR_W'(CH_T): glyph = 16'h3FED;
            CHAR_W'(CH_U): glyph = 16'hC0FF;
            CHAR_W'(CH_V): glyph = 16'hFCF3;
            CHAR_W'(CH_W): glyph = 16'hCCFA;
            CHAR_W'(CH_X): glyph = 16'hFFD2;
            CHAR_W'(CH_Y): glyph = 16'hFFD5;
            CHAR_W'(CH_Z): glyph = 16'h33F3;
            default:       glyph = BLANK_GLYPH;
        endcase
    end

endmodule

// File: rtl/led_scroll_ctrl.sv
// Four-digit 16-segment scroll sequencer: loops a host-written message right-to-left
// at a prescaled rate, then drains to blank on stop. LED_SCROLL_HOLD_EN adds a hold input.
module led_scroll_ctrl
    import led_scroll_pkg::*;
#(
    parameter int PRESCALE_W = 22,
    parameter int MSG_DEPTH  = 32,
    parameter int CHAR_W     = CHAR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef LED_SCROLL_HOLD_EN
    input  logic                         hold,
`endif
    input  logic                         msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] msg_addr,
    input  logic [CHAR_W-1:0]            msg_char,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         stop,
    output logic                         busy,
    output logic                         wrap,
    output logic [15:0]                  LEDa,
    output logic [15:0]                  LEDb,
    output logic [15:0]                  LEDc,
    output logic [15:0]                  LEDd
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;

    state_t                state_reg, state_next;
    logic [PRESCALE_W-1:0] presc_reg, presc_next;
    logic [AW-1:0]         idx_reg, idx_next;
    logic [LW-1:0]         len_reg, len_next;
    logic [2:0]            drain_reg, drain_next;
    logic                  busy_reg, busy_next;
    logic                  wrap_reg, wrap_next;
    logic [15:0]           digit_reg [4];
    logic [15:0]           digit_next [4];

    logic                  hold_w;
    logic                  tick;
    logic                  start_ok;
    logic                  shift_en;
    logic [15:0]           shift_glyph;
    logic [15:0]           msg_glyph;
    logic [CHAR_W-1:0]     msg_mem [MSG_DEPTH];

`ifdef LED_SCROLL_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Unreset message store; a same-edge write is seen by the next read, not this one.
    always_ff @(posedge clk) begin
        if (msg_we) begin
            msg_mem[msg_addr] <= msg_char;
        end
    end

    seg16_font #(
        .CHAR_W (CHAR_W)
    ) u_font (
        .code  (msg_mem[idx_reg]),
        .glyph (msg_glyph)
    );

    assign tick     = (state_reg != IDLE) && (presc_reg == '1) && !hold_w;
    assign start_ok = start && !stop && (msg_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (stop) state_next = DRAIN;
            DRAIN:   if (tick && (drain_reg == 3'd1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        presc_next  = presc_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        drain_next  = drain_reg;
        wrap_next   = 1'b0;
        shift_en    = 1'b0;
        shift_glyph = BLANK_GLYPH;
        case (state_reg)
            IDLE: begin
                presc_next = '0;
                if (start_ok) begin
                    len_next = msg_len;
                    idx_next = '0;
                end
            end
            RUN: begin
                if (!hold_w) presc_next = presc_reg + PRESCALE_W'(1);
                if (tick) begin
                    shift_en    = 1'b1;
                    shift_glyph = msg_glyph;
                    if ({1'b0, idx_reg} == len_reg - LW'(1)) begin
                        idx_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                    end
                end
                if (stop) drain_next = 3'(DRAIN_SHIFTS);
            end
            DRAIN: begin
                if (!hold_w) presc_next = presc_reg + PRESCALE_W'(1);
                if (tick) begin
                    shift_en   = 1'b1;
                    drain_next = drain_reg - 3'd1;
                end
            end
            default: presc_next = '0;
        endcase
    end

    assign busy_next = (state_next != IDLE);

    // Digit chain: LEDa (index 0) is leftmost, new glyphs enter at LEDd (index 3).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign digit_next[gi] = shift_en ? digit_reg[gi+1] : digit_reg[gi];
        end
    endgenerate
    assign digit_next[3] = shift_en ? shift_glyph : digit_reg[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            len_reg   <= '0;
            drain_reg <= '0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= BLANK_GLYPH;
            end
        end else begin
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            drain_reg <= drain_next;
            busy_reg  <= busy_next;
            wrap_reg  <= wrap_next;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= digit_next[i];
            end
        end
    end

    assign busy = busy_reg;
    assign wrap = wrap_reg;
    assign LEDa = digit_reg[0];
    assign LEDb = digit_reg[1];
    assign LEDc = digit_reg[2];
    assign LEDd = digit_reg[3];

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Self-checking bench for led_scroll_ctrl with an 8-cycle shift period.
// Hold scenarios are included when LED_SCROLL_HOLD_EN is defined.
module tb_led_scroll_ctrl;

    localparam int PW    = 3;
    localparam int PER   = 1 << PW;
    localparam int DEPTH = 32;
    localparam int CW    = 6;
    localparam int AW    = 5;
    localparam int LW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          msg_we = 1'b0;
    logic [AW-1:0] msg_addr = '0;
    logic [CW-1:0] msg_char = '0;
    logic [LW-1:0] msg_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
`ifdef LED_SCROLL_HOLD_EN
    logic          hold = 1'b0;
`endif
    logic          busy, wrap;
    logic [15:0]   LEDa, LEDb, LEDc, LEDd;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: mode 0 idle, 1 scrolling, 2 draining.
    int          m_mode = 0;
    int          m_len = 1, m_pos = 0, m_age = 0, m_drain = 0;
    logic [15:0] m_disp [4];
    logic        m_wrap = 1'b0;
    logic [CW-1:0] m_msg [DEPTH];

    led_scroll_ctrl #(
        .PRESCALE_W (PW),
        .MSG_DEPTH  (DEPTH),
        .CHAR_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef LED_SCROLL_HOLD_EN
        .hold     (hold),
`endif
        .msg_we   (msg_we),
        .msg_addr (msg_addr),
        .msg_char (msg_char),
        .msg_len  (msg_len),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .wrap     (wrap),
        .LEDa     (LEDa),
        .LEDb     (LEDb),
        .LEDc     (LEDc),
        .LEDd     (LEDd)
    );

    always #5 clk = ~clk;

    // Only codes with glyphs given in the datasheet are ever used as stimulus.
    function automatic logic [15:0] ref_font(input logic [CW-1:0] c);
        case (c)
            6'd1:    return 16'h0C3F;
            6'd3:    return 16'h30FF;
            6'd8:    return 16'hCC3F;
            6'd15:   return 16'h00FF;
            6'd16:   return 16'h1C3F;
            default: return (c == 6'd0 || c >= 6'd27) ? 16'hFFFF : 16'hxxxx;
        endcase
    endfunction

    function automatic logic [CW-1:0] rand_code();
        logic [CW-1:0] pool [6];
        pool = '{6'd0, 6'd1, 6'd3, 6'd8, 6'd15, 6'd16};
        if ($urandom_range(0, 3) == 0) return CW'(27 + $urandom_range(0, 36));
        return pool[$urandom_range(0, 5)];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_wrap = 1'b0;
        for (int i = 0; i < 4; i++) m_disp[i] = 16'hFFFF;
    endtask

    task automatic model_edge();
        logic        h;
        logic        tk;
        logic [15:0] g;
        h  = 1'b0;
`ifdef LED_SCROLL_HOLD_EN
        h  = hold;
`endif
        tk = 1'b0;
        m_wrap = 1'b0;
        if (m_mode == 0) begin
            if (start && !stop && msg_len != 0) begin
                m_mode = 1; m_len = int'(msg_len); m_pos = 0; m_age = 0;
            end
        end else begin
            if (!h) begin
                m_age++;
                tk = (m_age % PER == 0);
            end
            if (tk) begin
                g = (m_mode == 1) ? ref_font(m_msg[m_pos % m_len]) : 16'hFFFF;
                m_disp[0] = m_disp[1];
                m_disp[1] = m_disp[2];
                m_disp[2] = m_disp[3];
                m_disp[3] = g;
                if (m_mode == 1) begin
                    m_pos++;
                    m_wrap = (m_pos % m_len == 0);
                end else begin
                    m_drain--;
                    if (m_drain == 0) m_mode = 0;
                end
            end
            if (m_mode == 1 && stop) begin
                m_mode = 2; m_drain = 4;
            end
        end
        if (msg_we) m_msg[msg_addr] = msg_char;
    endtask

    task automatic check_all();
        chk("LEDa", LEDa, m_disp[0]);
        chk("LEDb", LEDb, m_disp[1]);
        chk("LEDc", LEDc, m_disp[2]);
        chk("LEDd", LEDd, m_disp[3]);
        chk("busy", {15'd0, busy}, {15'd0, (m_mode != 0)});
        chk("wrap", {15'd0, wrap}, {15'd0, m_wrap});
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic write_msg(input int a, input logic [CW-1:0] c);
        msg_we = 1'b1; msg_addr = AW'(a); msg_char = c;
        cyc();
        msg_we = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        msg_len = LW'(len); start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic drain_to_idle(input string tag);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!busy && m_mode == 0) break;
            cyc();
        end
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
        chk({tag, "_blankA"}, LEDa, 16'hFFFF);
        chk({tag, "_blankD"}, LEDd, 16'hFFFF);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_LEDb", LEDb, 16'hFFFF);
        rst = 1'b0;
        repeat (20) cyc();

        // "CO" scroll with explicit glyph/timing checks.
        write_msg(0, 6'd3);
        write_msg(1, 6'd15);
        pulse_start(2);
        repeat (8) cyc();
        chk("co_t8_LEDd", LEDd, 16'h30FF);
        repeat (8) cyc();
        chk("co_t16_LEDc", LEDc, 16'h30FF);
        chk("co_t16_LEDd", LEDd, 16'h00FF);
        chk("co_t16_wrap", {15'd0, wrap}, 16'd1);
        repeat (8) cyc();
        chk("co_t24_LEDd", LEDd, 16'h30FF);
        drain_to_idle("co");

        // Zero-length start is ignored.
        pulse_start(0);
        repeat (20) cyc();
        chk("len0_busy", {15'd0, busy}, 16'd0);

        // "HAP" then stop at a random phase; four blank shifts then nothing.
        write_msg(0, 6'd8);
        write_msg(1, 6'd1);
        write_msg(2, 6'd16);
        pulse_start(3);
        repeat (30 + $urandom_range(0, 7)) cyc();
        drain_to_idle("hap");
        repeat (24) cyc();

        // Simultaneous start and stop from idle: stop wins.
        msg_len = 3; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", {15'd0, busy}, 16'd0);
        repeat (10) cyc();

        // One-character message: wrap on every tick.
        write_msg(5, 6'd1);
        write_msg(0, 6'd1);
        pulse_start(1);
        repeat (32) cyc();
        chk("one_wrap", {15'd0, wrap}, 16'd1);
        drain_to_idle("one");

`ifdef LED_SCROLL_HOLD_EN
        // Hold for 20 cycles mid-period; remaining count resumes afterwards.
        write_msg(0, 6'd3);
        write_msg(1, 6'd15);
        pulse_start(2);
        repeat (5) cyc();
        hold = 1'b1;
        repeat (20) cyc();
        chk("hold_noshift", LEDd, 16'hFFFF);
        hold = 1'b0;
        repeat (2) cyc();
        chk("hold_pre", LEDd, 16'hFFFF);
        cyc();
        chk("hold_shift", LEDd, 16'h30FF);
        drain_to_idle("hold");
`endif

        // Randomized rounds: writes during scroll, stray starts, random stop phase.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int a = 0; a < len; a++) write_msg(a, rand_code());
            pulse_start(len);
            for (int c = 0; c < 20 + int'($urandom_range(0, 60)); c++) begin
                msg_we   = ($urandom_range(0, 3) == 0);
                msg_addr = AW'($urandom_range(0, 7));
                msg_char = rand_code();
                start    = ($urandom_range(0, 15) == 0);
                msg_len  = LW'($urandom_range(0, 8));
`ifdef LED_SCROLL_HOLD_EN
                hold     = ($urandom_range(0, 7) == 0);
`endif
                cyc();
            end
            msg_we = 1'b0; start = 1'b0;
`ifdef LED_SCROLL_HOLD_EN
            hold = 1'b0;
`endif
            drain_to_idle("rnd");
            repeat (3) cyc();
        end

        // Asynchronous reset in the middle of a scroll blanks at once.
        write_msg(0, 6'd8);
        write_msg(1, 6'd1);
        write_msg(2, 6'd16);
        pulse_start(3);
        repeat (13) cyc();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_LEDa", LEDa, 16'hFFFF);
        chk("arst_LEDc", LEDc, 16'hFFFF);
        chk("arst_LEDd", LEDd, 16'hFFFF);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        repeat (3) cyc();
        rst = 1'b0;
        repeat (12) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
